// File: rtl/window_scan_controller.sv
// Frame scan sequencer for the face-detection datapath: walks a detection window over the
// padded integral image, forms each window sum from four corners and hands it to the classifier.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for START; DET_COUNT holds the last frame's value
// S_FETCH    | read corners A,B,C,D (phases 0-3), drain last read (phase 4)
// S_ISSUE    | window offered to classifier, held until WIN_READY
// S_WAIT_RES | waiting for the classifier verdict
// S_ADVANCE  | step to the next raster position or finish
// S_DONE     | one-cycle end-of-frame pulse
module window_scan_controller #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int WIN    = 20,
    parameter int STEP   = 4,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic              ABORT,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RD,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              WIN_VALID,
    input  logic              WIN_READY,
    output logic [9:0]        WIN_X,
    output logic [9:0]        WIN_Y,
    output logic [DATA_W-1:0] WIN_SUM,
    input  logic              RES_VALID,
    input  logic              RES_FACE,
    output logic              DET_VALID,
    output logic [9:0]        DET_X,
    output logic [9:0]        DET_Y,
    output logic [15:0]       DET_COUNT,
    output logic              BUSY,
    output logic              DONE
);

    localparam int ROW = IMG_W + 1;
    localparam logic [9:0] X_LAST  = 10'(((IMG_W - WIN) / STEP) * STEP);
    localparam logic [9:0] Y_LAST  = 10'(((IMG_H - WIN) / STEP) * STEP);
    localparam logic [9:0] STEP_XY = 10'(STEP);
    localparam logic [ADDR_W-1:0] OFF_B    = ADDR_W'(WIN);
    localparam logic [ADDR_W-1:0] OFF_C    = ADDR_W'(WIN * ROW);
    localparam logic [ADDR_W-1:0] OFF_D    = ADDR_W'(WIN * ROW + WIN);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STEP * ROW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_RES,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [2:0]        phase;
    logic [9:0]        x_q, y_q;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] sum_q;
    logic              det_valid_q;
    logic [9:0]        det_x_q, det_y_q;
    logic [15:0]       det_count_q;

    logic x_last, y_last;
    logic start_scan, face_hit, step_x, step_y;

    // row_base tracks y*(IMG_W+1) incrementally so no multiplier is needed
    assign base   = row_base + ADDR_W'(x_q);
    assign x_last = (x_q == X_LAST);
    assign y_last = (y_q == Y_LAST);

    assign start_scan = (state == S_IDLE) && START;
    assign face_hit   = (state == S_WAIT_RES) && RES_VALID && RES_FACE && !ABORT;
    assign step_x     = (state == S_ADVANCE) && !ABORT && !x_last;
    assign step_y     = (state == S_ADVANCE) && !ABORT && x_last && !y_last;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        MEM_RD    = 1'b0;
        MEM_ADDR  = '0;
        WIN_VALID = 1'b0;
        BUSY      = 1'b1;
        DONE      = 1'b0;
        unique case (state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (phase < 3'd4) begin
                    MEM_RD = 1'b1;
                    case (phase[1:0])
                        2'd0:    MEM_ADDR = base;
                        2'd1:    MEM_ADDR = base + OFF_B;
                        2'd2:    MEM_ADDR = base + OFF_C;
                        default: MEM_ADDR = base + OFF_D;
                    endcase
                end else begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                WIN_VALID = 1'b1;
                if (WIN_READY) state_nx = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (RES_VALID) state_nx = S_ADVANCE;
            end
            S_ADVANCE: begin
                state_nx = (x_last && y_last) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                DONE     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // abort outranks every other event, including a verdict in the same cycle
        if (state != S_IDLE && ABORT) state_nx = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            phase       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            row_base    <= '0;
            sum_q       <= '0;
            det_valid_q <= 1'b0;
            det_x_q     <= '0;
            det_y_q     <= '0;
            det_count_q <= '0;
        end else begin
            det_valid_q <= 1'b0;

            if (start_scan) begin
                x_q         <= '0;
                y_q         <= '0;
                row_base    <= '0;
                det_count_q <= '0;
            end

            if (state == S_FETCH) begin
                phase <= phase + 3'd1;
            end else begin
                phase <= '0;
            end

            // read data lags the strobe by one cycle: phase n consumes corner n-1
            if (state == S_FETCH) begin
                case (phase)
                    3'd1:       sum_q <= MEM_RDATA;
                    3'd2, 3'd3: sum_q <= sum_q - MEM_RDATA;
                    3'd4:       sum_q <= sum_q + MEM_RDATA;
                    default:    sum_q <= sum_q;
                endcase
            end

            if (face_hit) begin
                det_valid_q <= 1'b1;
                det_x_q     <= x_q;
                det_y_q     <= y_q;
                if (det_count_q != 16'hFFFF) det_count_q <= det_count_q + 16'd1;
            end

            if (step_x) begin
                x_q <= x_q + STEP_XY;
            end else if (step_y) begin
                x_q      <= '0;
                y_q      <= y_q + STEP_XY;
                row_base <= row_base + ROW_STEP;
            end
        end
    end

    assign WIN_X     = x_q;
    assign WIN_Y     = y_q;
    assign WIN_SUM   = sum_q;
    assign DET_VALID = det_valid_q;
    assign DET_X     = det_x_q;
    assign DET_Y     = det_y_q;
    assign DET_COUNT = det_count_q;

endmodule

// File: tb/tb_window_scan_controller.sv
// Directed bench for window_scan_controller on a 24x24 frame of constant-1 pixels.
module tb_window_scan_controller;

    localparam int IMG_W  = 24;
    localparam int IMG_H  = 24;
    localparam int WIN    = 20;
    localparam int STEP   = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              CLK;
    logic              RESET_N;
    logic              START;
    logic              ABORT;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_RD;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              WIN_VALID;
    logic              WIN_READY;
    logic [9:0]        WIN_X;
    logic [9:0]        WIN_Y;
    logic [DATA_W-1:0] WIN_SUM;
    logic              RES_VALID;
    logic              RES_FACE;
    logic              DET_VALID;
    logic [9:0]        DET_X;
    logic [9:0]        DET_Y;
    logic [15:0]       DET_COUNT;
    logic              BUSY;
    logic              DONE;

    int total = 0;
    int bad   = 0;

    window_scan_controller #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .STEP(STEP),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_RDATA(MEM_RDATA),
        .WIN_VALID(WIN_VALID), .WIN_READY(WIN_READY),
        .WIN_X(WIN_X), .WIN_Y(WIN_Y), .WIN_SUM(WIN_SUM),
        .RES_VALID(RES_VALID), .RES_FACE(RES_FACE),
        .DET_VALID(DET_VALID), .DET_X(DET_X), .DET_Y(DET_Y),
        .DET_COUNT(DET_COUNT), .BUSY(BUSY), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // integral of a constant-1 image: ii(x,y) = x*y, row pitch IMG_W+1
    function automatic logic [DATA_W-1:0] ii(input logic [ADDR_W-1:0] a);
        int ai;
        ai = int'(a);
        return DATA_W'((ai % (IMG_W + 1)) * (ai / (IMG_W + 1)));
    endfunction

    initial MEM_RDATA = '0;
    always @(posedge CLK) begin
        if (MEM_RD) MEM_RDATA <= ii(MEM_ADDR);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_scan();
        START = 1'b1;
        check("busy_before_start", BUSY, 1'b0);
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start", BUSY, 1'b1);
        check("count_cleared", DET_COUNT, 16'd0);
    endtask

    // waits for the window, optionally stalls, accepts; returns in the WAIT_RES cycle
    task automatic wait_win(input int ex, input int ey, input int stall);
        int n;
        n = 0;
        while (!WIN_VALID && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("win_seen", WIN_VALID, 1'b1);
        if (!WIN_VALID) return;
        check("win_x", WIN_X, ex);
        check("win_y", WIN_Y, ey);
        check("win_sum", WIN_SUM, 400);
        for (int i = 0; i < stall; i++) begin
            @(negedge CLK);
            check("stall_valid", WIN_VALID, 1'b1);
            check("stall_x", WIN_X, ex);
            check("stall_y", WIN_Y, ey);
            check("stall_sum", WIN_SUM, 400);
            check("stall_no_rd", MEM_RD, 1'b0);
        end
        WIN_READY = 1'b1;
        @(negedge CLK);
        WIN_READY = 1'b0;
        check("win_dropped", WIN_VALID, 1'b0);
    endtask

    task automatic respond(input bit face, input int ex, input int ey);
        RES_VALID = 1'b1;
        RES_FACE  = face;
        @(negedge CLK);
        RES_VALID = 1'b0;
        RES_FACE  = 1'b0;
        check("det_valid", DET_VALID, face);
        if (face) begin
            check("det_x", DET_X, ex);
            check("det_y", DET_Y, ey);
        end
    endtask

    task automatic wait_done(input int exp_count);
        int n;
        n = 0;
        while (!DONE && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("done_seen", DONE, 1'b1);
        check("done_busy", BUSY, 1'b1);
        @(negedge CLK);
        check("done_one_cycle", DONE, 1'b0);
        check("idle_after_done", BUSY, 1'b0);
        check("final_count", DET_COUNT, exp_count);
    endtask

    initial begin
        int exp_addr[4];
        exp_addr = '{0, 20, 500, 520};

        RESET_N   = 1'b0;
        START     = 1'b0;
        ABORT     = 1'b0;
        WIN_READY = 1'b0;
        RES_VALID = 1'b0;
        RES_FACE  = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("rst_busy", BUSY, 1'b0);
        check("rst_rd", MEM_RD, 1'b0);
        check("rst_addr", MEM_ADDR, 0);
        check("rst_win_valid", WIN_VALID, 1'b0);
        check("rst_win_sum", WIN_SUM, 0);
        check("rst_det_valid", DET_VALID, 1'b0);
        check("rst_count", DET_COUNT, 0);
        check("rst_done", DONE, 1'b0);

        // basic scan: corner order, 5-cycle latency, backpressure on window (4,0)
        start_scan();
        for (int i = 0; i < 4; i++) begin
            check("fetch_rd", MEM_RD, 1'b1);
            check("fetch_addr", MEM_ADDR, exp_addr[i]);
            @(negedge CLK);
        end
        check("drain_no_rd", MEM_RD, 1'b0);
        check("drain_no_valid", WIN_VALID, 1'b0);
        @(negedge CLK);
        check("latency_valid", WIN_VALID, 1'b1);
        wait_win(0, 0, 0);  respond(1'b0, 0, 0);
        wait_win(4, 0, 10); respond(1'b0, 4, 0);
        wait_win(0, 4, 0);  respond(1'b0, 0, 4);
        wait_win(4, 4, 0);  respond(1'b0, 4, 4);
        wait_done(0);

        // detections on (4,0) and (4,4)
        start_scan();
        wait_win(0, 0, 0); respond(1'b0, 0, 0);
        wait_win(4, 0, 0); respond(1'b1, 4, 0);
        wait_win(0, 4, 0); respond(1'b0, 0, 4);
        wait_win(4, 4, 0); respond(1'b1, 4, 4);
        wait_done(2);

        // abort coinciding with a face verdict on window 3
        start_scan();
        wait_win(0, 0, 0); respond(1'b1, 0, 0);
        check("partial_count", DET_COUNT, 1);
        wait_win(4, 0, 0); respond(1'b0, 4, 0);
        wait_win(0, 4, 0);
        RES_VALID = 1'b1;
        RES_FACE  = 1'b1;
        ABORT     = 1'b1;
        @(negedge CLK);
        RES_VALID = 1'b0;
        RES_FACE  = 1'b0;
        ABORT     = 1'b0;
        check("abort_busy", BUSY, 1'b0);
        check("abort_det", DET_VALID, 1'b0);
        check("abort_done", DONE, 1'b0);
        check("abort_rd", MEM_RD, 1'b0);
        check("abort_valid", WIN_VALID, 1'b0);
        check("abort_count", DET_COUNT, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("abort_no_done", DONE, 1'b0);
            check("abort_stay_idle", BUSY, 1'b0);
        end

        // reset asserted during FETCH of window (4,0)
        start_scan();
        wait_win(0, 0, 0); respond(1'b1, 0, 0);
        @(negedge CLK);
        @(negedge CLK);
        check("pre_rst_rd", MEM_RD, 1'b1);
        check("pre_rst_x", WIN_X, 4);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_busy", BUSY, 1'b0);
        check("mid_rst_rd", MEM_RD, 1'b0);
        check("mid_rst_addr", MEM_ADDR, 0);
        check("mid_rst_x", WIN_X, 0);
        check("mid_rst_sum", WIN_SUM, 0);
        check("mid_rst_count", DET_COUNT, 0);
        check("mid_rst_det_x", DET_X, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("post_rst_idle", BUSY, 1'b0);

        // restart; START held high mid-scan must not clear the count or restart
        start_scan();
        wait_win(0, 0, 0); respond(1'b1, 0, 0);
        START = 1'b1;
        wait_win(4, 0, 0); respond(1'b0, 4, 0);
        wait_win(0, 4, 0); respond(1'b0, 0, 4);
        START = 1'b0;
        wait_win(4, 4, 0); respond(1'b0, 4, 4);
        wait_done(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
